// File: rtl/mem_burst_tester_pkg.sv
// Shared types and constants for the DDR burst traffic tester.
package mem_test_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_NEXT
   } state_t;

   // Width of one pattern lane; data words are this lane replicated.
   localparam int PAT_BITS = 32;

endpackage

// File: rtl/mem_burst_tester_if.sv
// Burst request/data bus between the tester (master) and mem_burst (slave).
interface mem_burst_if #(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 24
);
   logic                     rd_burst_req;
   logic                     wr_burst_req;
   logic [9:0]               rd_burst_len;
   logic [9:0]               wr_burst_len;
   logic [ADDR_BITS-1:0]     rd_burst_addr;
   logic [ADDR_BITS-1:0]     wr_burst_addr;
   logic                     wr_burst_data_req;
   logic [MEM_DATA_BITS-1:0] wr_burst_data;
   logic                     rd_burst_data_valid;
   logic [MEM_DATA_BITS-1:0] rd_burst_data;
   logic                     rd_burst_finish;
   logic                     wr_burst_finish;

   modport master (
      output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
             rd_burst_addr, wr_burst_addr, wr_burst_data,
      input  wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
             rd_burst_finish, wr_burst_finish
   );

   modport slave (
      input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
             rd_burst_addr, wr_burst_addr, wr_burst_data,
      output wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
             rd_burst_finish, wr_burst_finish
   );
endinterface

// File: rtl/mem_burst_tester_pattern_gen.sv
// Test pattern for word idx of the burst at base: (base + idx) mod 2^32,
// replicated across the data word.
module mem_pattern_gen
   import mem_test_pkg::*;
#(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 24
) (
   input  logic [ADDR_BITS-1:0]     base,
   input  logic [15:0]              idx,
   output logic [MEM_DATA_BITS-1:0] pattern
);
   localparam int REP = MEM_DATA_BITS / PAT_BITS;

   logic [PAT_BITS-1:0] lane;

   // Form one 32-bit lane and replicate it.
   always_comb begin
      lane    = PAT_BITS'(base) + PAT_BITS'(idx);
      pattern = {REP{lane}};
   end
endmodule

// File: rtl/mem_burst_tester.sv
// Write/readback/compare traffic loop over a DDR window with sticky status.
module mem_burst_tester
   import mem_test_pkg::*;
#(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 24,
   parameter int BURST_LEN     = 128,
   parameter int TEST_WORDS    = 4096,
   parameter int TIMEOUT_CYC   = 65535
) (
   input  logic                 mem_clk,
   input  logic                 rst_n,
   input  logic                 init_calib_complete,
   input  logic                 test_en,
   mem_burst_if.master          bus,
   output logic                 error,
   output logic [15:0]          error_cnt,
   output logic [ADDR_BITS-1:0] first_err_addr,
   output logic                 timeout,
   output logic [15:0]          loop_cnt
);
   localparam int WD_BITS = $clog2(TIMEOUT_CYC + 1);

   state_t                   state;
   logic [ADDR_BITS-1:0]     base;
   logic [ADDR_BITS-1:0]     next_base;
   logic                     wrap;
   logic [15:0]              wr_cnt;
   logic [15:0]              rd_cnt;
   logic [WD_BITS-1:0]       wdog;
   logic                     wd_expired;
   logic [MEM_DATA_BITS-1:0] wr_pat;
   logic [MEM_DATA_BITS-1:0] rd_exp;
   logic                     beat_err;
   logic                     short_err;
   logic [1:0]               n_err;
   logic [16:0]              err_sum;

   assign bus.rd_burst_len = 10'(BURST_LEN);
   assign bus.wr_burst_len = 10'(BURST_LEN);

   mem_pattern_gen #(.MEM_DATA_BITS(MEM_DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_wr_pat (
      .base(base), .idx(wr_cnt), .pattern(wr_pat)
   );

   mem_pattern_gen #(.MEM_DATA_BITS(MEM_DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_rd_pat (
      .base(base), .idx(rd_cnt), .pattern(rd_exp)
   );

   // Next window address, read-beat error classification and watchdog limit.
   always_comb begin
      wrap       = (base + ADDR_BITS'(BURST_LEN)) == ADDR_BITS'(TEST_WORDS);
      next_base  = wrap ? '0 : base + ADDR_BITS'(BURST_LEN);
      beat_err   = bus.rd_burst_data_valid &&
                   ((rd_cnt >= 16'(BURST_LEN)) || (bus.rd_burst_data != rd_exp));
      // A beat arriving on the finish edge still counts towards the total.
      short_err  = bus.rd_burst_finish &&
                   ((17'(rd_cnt) + 17'(bus.rd_burst_data_valid)) < 17'(BURST_LEN));
      n_err      = 2'(beat_err) + 2'(short_err);
      err_sum    = 17'(error_cnt) + 17'(n_err);
      wd_expired = (wdog == WD_BITS'(TIMEOUT_CYC - 1));
   end

   // Burst sequencing FSM with registered requests, data and status.
   always_ff @(posedge mem_clk) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         base              <= '0;
         wr_cnt            <= '0;
         rd_cnt            <= '0;
         wdog              <= '0;
         bus.rd_burst_req  <= 1'b0;
         bus.wr_burst_req  <= 1'b0;
         bus.rd_burst_addr <= '0;
         bus.wr_burst_addr <= '0;
         bus.wr_burst_data <= '0;
         error             <= 1'b0;
         error_cnt         <= '0;
         first_err_addr    <= '0;
         timeout           <= 1'b0;
         loop_cnt          <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (init_calib_complete && test_en) begin
                  state             <= S_WRITE;
                  bus.wr_burst_req  <= 1'b1;
                  bus.wr_burst_addr <= base;
                  wr_cnt            <= '0;
                  wdog              <= '0;
               end
            end
            S_WRITE: begin
               if (bus.wr_burst_data_req) begin
                  bus.wr_burst_data <= wr_pat;
                  wr_cnt            <= wr_cnt + 16'd1;
               end
               if (bus.wr_burst_finish) begin
                  state             <= S_READ;
                  bus.wr_burst_req  <= 1'b0;
                  bus.rd_burst_req  <= 1'b1;
                  bus.rd_burst_addr <= base;
                  rd_cnt            <= '0;
                  wdog              <= '0;
               end else if (wd_expired) begin
                  state            <= S_IDLE;
                  timeout          <= 1'b1;
                  bus.wr_burst_req <= 1'b0;
                  wdog             <= '0;
               end else begin
                  wdog <= wdog + WD_BITS'(1);
               end
            end
            S_READ: begin
               if (bus.rd_burst_data_valid && (rd_cnt != '1))
                  rd_cnt <= rd_cnt + 16'd1;
               if (n_err != 2'd0) begin
                  error     <= 1'b1;
                  error_cnt <= err_sum[16] ? '1 : err_sum[15:0];
                  if (error_cnt == '0)
                     first_err_addr <= base + ADDR_BITS'(rd_cnt);
               end
               if (bus.rd_burst_finish) begin
                  state            <= S_NEXT;
                  bus.rd_burst_req <= 1'b0;
                  wdog             <= '0;
               end else if (wd_expired) begin
                  state            <= S_IDLE;
                  timeout          <= 1'b1;
                  bus.rd_burst_req <= 1'b0;
                  wdog             <= '0;
               end else begin
                  wdog <= wdog + WD_BITS'(1);
               end
            end
            S_NEXT: begin
               base <= next_base;
               if (wrap)
                  loop_cnt <= loop_cnt + 16'd1;
               if (test_en) begin
                  state             <= S_WRITE;
                  bus.wr_burst_req  <= 1'b1;
                  bus.wr_burst_addr <= next_base;
                  wr_cnt            <= '0;
                  wdog              <= '0;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_burst_tester.md
Name: mem_burst_tester

Overview:
- Traffic generator and checker that sits directly upstream of `mem_burst`. It drives `mem_burst`'s burst request/data interface.
- Loops over a configurable DDR3 window: writes one burst of a known pattern, reads the same burst back, compares every word, then advances.
- Produces sticky error status, error counters and a loop counter for LEDs / ILA in the DDR3 PL demo.

Parameters:
- MEM_DATA_BITS, 64, width of one burst data word; must be a multiple of 32.
- ADDR_BITS, 24, word address width; matches `mem_burst` `rd_burst_addr`/`wr_burst_addr`.
- BURST_LEN, 128, words per burst; range 1..1023.
- TEST_WORDS, 4096, size of the test window in words; must be a multiple of BURST_LEN.
- TIMEOUT_CYC, 65535, maximum cycles to wait for a burst finish.

Ports:
- mem_clk  in  1  ui clock, shared with `mem_burst`
- rst_n  in  1  synchronous active-low reset
- init_calib_complete  in  1  DDR calibration done
- test_en  in  1  run enable
- rd_burst_req  out  1  read burst request
- wr_burst_req  out  1  write burst request
- rd_burst_len  out  10  constant BURST_LEN
- wr_burst_len  out  10  constant BURST_LEN
- rd_burst_addr  out  ADDR_BITS  read start word address
- wr_burst_addr  out  ADDR_BITS  write start word address
- wr_burst_data_req  in  1  `mem_burst` consumes one write word
- wr_burst_data  out  MEM_DATA_BITS  write data
- rd_burst_data_valid  in  1  read word valid
- rd_burst_data  in  MEM_DATA_BITS  read word
- rd_burst_finish  in  1  read burst done pulse
- wr_burst_finish  in  1  write burst done pulse
- error  out  1  sticky mismatch flag
- error_cnt  out  16  mismatching words, saturating
- first_err_addr  out  ADDR_BITS  word address of the first mismatch
- timeout  out  1  sticky watchdog flag
- loop_cnt  out  16  completed passes over the window, wraps

Behaviour:

Reset (rst_n low at a clock edge):
- All outputs become 0; state goes to S_IDLE; base address goes to 0.
- A reset mid-burst drops the requests at the next edge. No finish is awaited.

Pattern:
- For word k of the burst at base A, the 32-bit value is P = A + k (zero-extended, mod 2^32).
- The word value is P replicated MEM_DATA_BITS/32 times.

State S_IDLE:
- Go to S_WRITE when init_calib_complete=1 and test_en=1.
- On entry set wr_burst_req=1, wr_burst_addr=A, write word counter=0.

State S_WRITE:
- On each edge with wr_burst_data_req=1:
  - register wr_burst_data = pattern(A, counter);
  - increment the counter.
- Data is therefore valid the cycle after the request, which matches `mem_burst`'s registered write enable.
- wr_burst_req drops on the edge where wr_burst_finish=1.
- On that edge go to S_READ: rd_burst_req=1, rd_burst_addr=A, read counter=0.

State S_READ:
- On each edge with rd_burst_data_valid=1:
  - compare rd_burst_data against pattern(A, read counter);
  - increment the read counter.
- On mismatch:
  - set error;
  - increment error_cnt, saturating at 16'hFFFF;
  - if error_cnt was 0, capture first_err_addr = A + read counter.
- A valid beat with read counter ≥ BURST_LEN counts as a mismatch.
- On the edge where rd_burst_finish=1: drop rd_burst_req and go to S_NEXT.
- If rd_burst_finish arrives with fewer than BURST_LEN beats received, add 1 error.

State S_NEXT (one cycle):
- A = A + BURST_LEN.
- If the new A equals TEST_WORDS: A = 0 and loop_cnt increments.
- If test_en=1 go to S_WRITE (issue the next write); otherwise go to S_IDLE.

Other rules:
- test_en deasserted mid-burst: the current write/read pair completes, then the block idles.
- rd_burst_req and wr_burst_req are never high together.
- Watchdog: a counter runs in S_WRITE and S_READ and clears on every state change.
  - At TIMEOUT_CYC: set timeout, drop both requests, go to S_IDLE.
  - The base address is not advanced.
- init_calib_complete falling while running has no effect on the current burst. S_IDLE waits for it again.
- error, timeout and first_err_addr clear only on reset.

Decomposition:
- Package `mem_test_pkg`:
  - state encoding constants S_IDLE, S_WRITE, S_READ, S_NEXT;
  - pattern-width constant (32).
- One sub-module, `mem_pattern_gen`:
  - combinational pattern(A, k) replicated to MEM_DATA_BITS;
  - instanced twice, once for the write path and once for the expected read data.

Test Plan:
- Behavioural `mem_burst` + memory model, BURST_LEN=4, TEST_WORDS=16, 64-bit data -> write words at A=0 are 0x00000000_00000000 .. 0x00000003_00000003; readback clean; error=0, error_cnt=0.
- Run 4 bursts -> addresses 0, 4, 8, 12, then wrap to 0; loop_cnt=1 after the 4th S_NEXT.
- Memory model flips bit 0 of the word at address 6 -> error=1, error_cnt increments by 1 per pass, first_err_addr=6.
- Model never asserts wr_burst_finish, TIMEOUT_CYC=100 -> timeout=1 after 100 cycles in S_WRITE; both requests low; state S_IDLE.
- test_en drops in the middle of a read burst -> the read completes, the S_NEXT address advance occurs, then the block idles with no new wr_burst_req.
- rst_n low mid-write for 1 cycle -> wr_burst_req=0 next edge; all counters 0; restart writes at A=0.
